// File: rtl/lstm_seq_controller.sv
// lstm_seq_controller: steps an input sequence through the LSTM layer one
// time step at a time. It clears the recurrent state once per sequence,
// accepts each x_t over a valid/ready handshake, and holds it on layer_x
// while the layer settles. It then captures h_t and returns it downstream
// with a last flag, and pulses done when the sequence completes.
module lstm_seq_controller #(
    parameter int INPUT_SIZE    = 128,
    parameter int HIDDEN_SIZE   = 64,
    parameter int SEQ_LEN_W     = 8,
    parameter int LAYER_LATENCY = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [SEQ_LEN_W-1:0]   seq_len,
    output logic                   busy,
    output logic                   done,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INPUT_SIZE-1:0]  in_data,
    output logic [INPUT_SIZE-1:0]  layer_x,
    output logic                   layer_clr,
    input  logic [HIDDEN_SIZE-1:0] layer_h,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [HIDDEN_SIZE-1:0] out_data,
    output logic                   out_last
);

    localparam int LAT_W = (LAYER_LATENCY < 1) ? 1 : $clog2(LAYER_LATENCY + 1);
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(LAYER_LATENCY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_WAIT,
        S_OUT,
        S_FIN
    } state_t;

    state_t                 state_q, state_d;
    logic [SEQ_LEN_W-1:0]   step_cnt_q, step_cnt_d;
    logic [SEQ_LEN_W-1:0]   len_q, len_d;
    logic [LAT_W-1:0]       lat_cnt_q, lat_cnt_d;
    logic [INPUT_SIZE-1:0]  layer_x_q, layer_x_d;
    logic [HIDDEN_SIZE-1:0] out_data_q, out_data_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   in_ready_q, in_ready_d;
    logic                   layer_clr_q, layer_clr_d;
    logic                   out_valid_q, out_valid_d;
    logic                   out_last_q, out_last_d;

    // Next-state, datapath and registered-output decode for the step sequencer.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
        state_d    = state_q;
        step_cnt_d = step_cnt_q;
        len_d      = len_q;
        lat_cnt_d  = lat_cnt_q;
        layer_x_d  = layer_x_q;
        out_data_d = out_data_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (seq_len != '0) begin
                        len_d      = seq_len;
                        step_cnt_d = '0;
                        state_d    = S_CLEAR;
                    end else begin
                        state_d = S_FIN;
                    end
                end
            end
            S_CLEAR: state_d = S_FEED;
            S_FEED: begin
                if (in_valid && in_ready_q) begin
                    layer_x_d = in_data;
                    lat_cnt_d = LAT_LOAD;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                // The counter runs down through LAYER_LATENCY settle cycles;
                // h_t is sampled on the edge after it reaches zero, so the
                // first out_valid cycle lands LAYER_LATENCY+1 edges after acceptance.
                if (lat_cnt_q == '0) begin
                    out_data_d = layer_h;
                    state_d    = S_OUT;
                end else begin
                    lat_cnt_d = lat_cnt_q - 1'b1;
                end
            end
            S_OUT: begin
                if (out_valid_q && out_ready) begin
                    if (out_last_q) begin
                        state_d = S_FIN;
                    end else begin
                        step_cnt_d = step_cnt_q + 1'b1;
                        state_d    = S_FEED;
                    end
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so they are registered yet
        // line up with the state they describe.
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_FIN);
        in_ready_d  = (state_d == S_FEED);
        layer_clr_d = (state_d == S_CLEAR);
        out_valid_d = (state_d == S_OUT);
        out_last_d  = (state_d == S_OUT) && (step_cnt_d == len_d - 1'b1);
    end

    // State, counters, datapath registers and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: layer_x/out_data are plain registers that must read 0 after reset, so they are reset here too.
            state_q     <= S_IDLE;
            step_cnt_q  <= '0;
            len_q       <= '0;
            lat_cnt_q   <= '0;
            layer_x_q   <= '0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            layer_clr_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            step_cnt_q  <= step_cnt_d;
            len_q       <= len_d;
            lat_cnt_q   <= lat_cnt_d;
            layer_x_q   <= layer_x_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            in_ready_q  <= in_ready_d;
            layer_clr_q <= layer_clr_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign in_ready  = in_ready_q;
    assign layer_clr = layer_clr_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign layer_x   = layer_x_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_lstm_seq_controller.sv
// Testbench for lstm_seq_controller: a transaction-level reference model is
// compared against the DUT on every cycle. Directed scenarios add literal
// expectations for beat counts, latency and data values.
module tb_lstm_seq_controller;

    localparam int IW  = 128;
    localparam int HW  = 64;
    localparam int SW  = 8;
    localparam int LAT = 4;

    logic          clk       = 1'b0;
    logic          reset     = 1'b0;
    logic          start     = 1'b0;
    logic [SW-1:0] seq_len   = '0;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b0;
    logic [IW-1:0] in_data   = '0;
    logic [HW-1:0] layer_h   = '0;
    logic          busy, done, in_ready, layer_clr, out_valid, out_last;
    logic [IW-1:0] layer_x;
    logic [HW-1:0] out_data;

    lstm_seq_controller #(
        .INPUT_SIZE(IW), .HIDDEN_SIZE(HW), .SEQ_LEN_W(SW), .LAYER_LATENCY(LAT)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .seq_len(seq_len),
        .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .layer_x(layer_x), .layer_clr(layer_clr),
        .layer_h(layer_h), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [IW-1:0] act, input logic [IW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: tracks the sequence as phases of a transaction
    // (clear pulse, waiting for an input, settling countdown, output beat,
    // completion pulse) with a count of beats still owed.
    logic          m_busy, m_done, m_in_ready, m_clr, m_out_valid, m_out_last;
    logic [IW-1:0] m_x;
    logic [HW-1:0] m_h;
    int            m_left, m_count;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy <= 0; m_done <= 0; m_in_ready <= 0; m_clr <= 0;
            m_out_valid <= 0; m_out_last <= 0; m_x <= '0; m_h <= '0;
            m_left <= 0; m_count <= 0;
        end else if (!m_busy) begin
            if (start) begin
                m_busy <= 1;
                if (seq_len == 0) m_done <= 1;
                else begin
                    m_clr  <= 1;
                    m_left <= int'(seq_len);
                end
            end
        end else if (m_done) begin
            m_done <= 0;
            m_busy <= 0;
        end else if (m_clr) begin
            m_clr      <= 0;
            m_in_ready <= 1;
        end else if (m_in_ready) begin
            if (in_valid) begin
                m_in_ready <= 0;
                m_x        <= in_data;
                m_count    <= LAT + 1;
            end
        end else if (m_count > 0) begin
            m_count <= m_count - 1;
            if (m_count == 1) begin
                m_out_valid <= 1;
                m_h         <= layer_h;
                m_out_last  <= (m_left == 1);
            end
        end else if (m_out_valid && out_ready) begin
            m_out_valid <= 0;
            m_out_last  <= 0;
            m_left      <= m_left - 1;
            if (m_left == 1) m_done <= 1;
            else m_in_ready <= 1;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    bit cmp_en = 0;
    always @(negedge clk) begin
        if (cmp_en) begin
            check("busy",      busy,      m_busy);
            check("done",      done,      m_done);
            check("in_ready",  in_ready,  m_in_ready);
            check("layer_clr", layer_clr, m_clr);
            check("out_valid", out_valid, m_out_valid);
            check("out_last",  out_last,  m_out_last);
            check("layer_x",   layer_x,   m_x);
            check("out_data",  out_data,  m_h);
        end
    end

    // Event counters sampled at the active edge (pre-edge DUT values).
    int cyc = 0, beats = 0, lasts = 0, clrs = 0, dones = 0, accs = 0, acc_edge = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!reset) begin
            if (out_valid && out_ready) begin
                beats <= beats + 1;
                if (out_last) lasts <= lasts + 1;
            end
            if (layer_clr) clrs  <= clrs + 1;
            if (done)      dones <= dones + 1;
            if (in_valid && in_ready) begin
                accs     <= accs + 1;
                acc_edge <= cyc + 1;
            end
        end
    end

    bit scramble = 0;
    task automatic tick();
        @(posedge clk);
        #1;
        if (scramble) begin
            in_data = {16{8'(cyc)}};
            layer_h = {4{16'(cyc * 7 + 3)}};
        end
    endtask

    task automatic pulse_start(input int len);
        seq_len = SW'(len);
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL %s: timeout after %0d cycles waiting for done", name, budget);
        end
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},      busy,      '0);
        check({tag, "_done"},      done,      '0);
        check({tag, "_in_ready"},  in_ready,  '0);
        check({tag, "_clr"},       layer_clr, '0);
        check({tag, "_out_valid"}, out_valid, '0);
        check({tag, "_out_last"},  out_last,  '0);
        check({tag, "_layer_x"},   layer_x,   '0);
        check({tag, "_out_data"},  out_data,  '0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int b0, l0, c0, d0, a0, n;

    initial begin
        #1 reset = 1'b1;
        #2 cmp_en = 1;
        repeat (3) tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();

        // Three steps, both handshakes immediate, fixed data patterns.
        in_data = {16{8'hA5}};
        layer_h = {4{16'h1234}};
        in_valid = 1'b1;
        out_ready = 1'b1;
        b0 = beats; l0 = lasts; c0 = clrs; d0 = dones;
        pulse_start(3);
        n = 0;
        while (!out_valid && n < 50) begin tick(); n++; end
        check("first_latency", cyc - acc_edge, 5);
        wait_done(200, "seq3_done");
        check("seq3_beats", beats - b0, 3);
        check("seq3_lasts", lasts - l0, 1);
        check("seq3_clrs",  clrs - c0, 1);
        check("seq3_dones", dones - d0, 1);
        check("seq3_idle",  busy, 1'b0);
        check("seq3_out_data", out_data, {4{16'h1234}});
        check("seq3_layer_x",  layer_x,  {16{8'hA5}});

        // Downstream stall for 10 cycles in OUT with changing layer_h.
        scramble = 1;
        out_ready = 1'b0;
        b0 = beats;
        pulse_start(2);
        n = 0;
        while (!out_valid && n < 50) begin tick(); n++; end
        for (int i = 0; i < 10; i++) begin
            tick();
            check("stall_valid",    out_valid, 1'b1);
            check("stall_data",     out_data,  m_h);
            check("stall_in_ready", in_ready,  1'b0);
        end
        out_ready = 1'b1;
        tick();
        check("stall_release_valid", out_valid, 1'b0);
        check("stall_release_feed",  in_ready,  1'b1);
        wait_done(200, "stall_done");
        check("stall_beats", beats - b0, 2);

        // Zero-length sequence: immediate done, no clear, no beats.
        b0 = beats; c0 = clrs;
        pulse_start(0);
        check("len0_done", done, 1'b1);
        check("len0_busy", busy, 1'b1);
        tick();
        check("len0_done_off", done, 1'b0);
        check("len0_idle",     busy, 1'b0);
        check("len0_clrs",  clrs - c0, 0);
        check("len0_beats", beats - b0, 0);

        // start pulsed mid-sequence and in_valid held through WAIT are ignored.
        b0 = beats; a0 = accs; d0 = dones;
        pulse_start(2);
        repeat (8) tick();
        pulse_start(5);
        wait_done(200, "ignore_done");
        check("ignore_beats", beats - b0, 2);
        check("ignore_accs",  accs - a0, 2);
        check("ignore_dones", dones - d0, 1);
        repeat (3) tick();
        check("ignore_idle", busy, 1'b0);

        // Asynchronous reset in WAIT of step 2, then a clean 1-step run.
        a0 = accs;
        pulse_start(3);
        n = 0;
        while ((accs - a0) < 2 && n < 100) begin tick(); n++; end
        check("rst_reached_step2", accs - a0, 2);
        repeat (2) tick();
        #2 reset = 1'b1;
        #1 check_all_zero("midrst");
        #2 reset = 1'b0;
        b0 = beats;
        repeat (10) tick();
        check("midrst_no_beats", beats - b0, 0);
        b0 = beats; l0 = lasts;
        pulse_start(1);
        wait_done(100, "post_rst_done");
        check("post_rst_beats", beats - b0, 1);
        check("post_rst_lasts", lasts - l0, 1);

        // Maximum length: 255 beats, no counter wrap, single last.
        b0 = beats; l0 = lasts;
        pulse_start(255);
        wait_done(3000, "max_done");
        check("max_beats", beats - b0, 255);
        check("max_lasts", lasts - l0, 1);

        cmp_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
